axi_lite_regbank: RTL and testbench
===================================

AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI-lite data width (32 only).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte-address width.
REQ-003 SHALL have parameter NUM_STATUS, default 13, count of read-only status words.
REQ-004 SHALL have parameter NUM_CTRL, default 8, count of read/write control words.
REQ-005 SHALL have parameter CTRL_INIT, default all-zero, NUM_CTRL*32 bits, reset value of the control words.
REQ-006 SHALL have parameter ID_WORD, default 32'hdeadbeef, constant read-only identification word.
REQ-007 SHALL have port S_AXI_ACLK, input, 1, the single clock.
REQ-008 SHALL have port S_AXI_ARESET, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port status_in, input, NUM_STATUS*32, the status words.
REQ-010 SHALL have port ctrl_out, output, NUM_CTRL*32, the control word values.
REQ-011 SHALL have port ctrl_wr_pulse, output, NUM_CTRL, one-cycle commit strobe per control word.
REQ-012 SHALL have the standard AXI4-lite slave AW/W/B/AR/R ports with widths set by the parameters.

Function
REQ-013 Word index = addr[C_S_AXI_ADDR_WIDTH-1:2]; mapping: 0..NUM_STATUS-1 status, then NUM_CTRL control words, then one ID_WORD, then one SNAP_CTRL word; all other indices are unmapped.
REQ-014 AW and W SHALL be accepted independently into one-entry holding registers; AWREADY = AW holder empty and BVALID low; WREADY = W holder empty and BVALID low.
REQ-015 Commit cycle = both holders full and BVALID low; at that edge, the targeted control word updates per WSTRB byte lanes, BVALID rises, and both holders clear.
REQ-016 ctrl_wr_pulse[i] SHALL be high for exactly the one cycle after a commit to control word i, including when WSTRB=0.
REQ-017 A write to a status, ID or unmapped index SHALL change no state and SHALL return BRESP=SLVERR (2'b10); otherwise BRESP=OKAY.
REQ-018 BVALID SHALL hold until BREADY; new AW/W SHALL NOT be accepted while BVALID is high.
REQ-019 ARREADY = RVALID low and no read pending; on an AR handshake, RDATA/RRESP SHALL be registered and RVALID SHALL rise on the next edge (1-cycle latency).
REQ-020 RVALID and RDATA SHALL hold until RREADY.
REQ-021 Reads of an unmapped index SHALL return RDATA=0 and RRESP=SLVERR.
REQ-022 Snapshot: a read of status index 0 SHALL copy all status_in into a shadow bank at the AR-handshake edge; when SNAP_CTRL bit0=1, status reads SHALL return the shadow, otherwise the live value.
REQ-023 SNAP_CTRL SHALL be read/write with only bit0 implemented; other bits SHALL read 0.
REQ-024 If a read and a write commit hit the same control word on the same edge, the read SHALL return the pre-commit value.
REQ-025 Read and write channels SHALL operate concurrently with no mutual stall.

Reset
REQ-026 On S_AXI_ARESET: all READY and VALID outputs 0, BRESP/RRESP/RDATA 0, holders empty, ctrl_out=CTRL_INIT, ctrl_wr_pulse 0, shadow bank 0, SNAP_CTRL 0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no partial register update; reset release SHALL need no handshake to recover.

Structure
REQ-028 Response codes (OKAY, SLVERR) and the SNAP_CTRL bit position SHALL live in a shared package.
REQ-029 The write path (holders, commit, B channel) SHALL be one sub-module, axi_lite_wr_channel; decode, read path and register storage SHALL stay in the top.

Verification
REQ-030 Write 0x12345678 to index 13 (ctrl0) with WSTRB=4'b0101 after reset -> ctrl_out[31:0]=0x00340078, ctrl_wr_pulse[0] high 1 cycle, BRESP=OKAY.
REQ-031 W presented 3 cycles before AW -> WREADY handshake immediately, commit on the cycle after AW handshake, exactly one BVALID.
REQ-032 Write index 2 (status) and read index 60 (unmapped) -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no state change.
REQ-033 Set SNAP_CTRL=1; status_in word1=0xA; read index 0; change word1 to 0xB; read index 1 -> returns 0xA.
REQ-034 Hold RREADY low 5 cycles -> RVALID/RDATA stable, ARREADY low throughout.
REQ-035 Assert reset between AW and W handshakes -> after release, ctrl_out=CTRL_INIT, no BVALID, next write completes normally.

Source files
------------

// File: rtl/axi_lite_regbank_pkg.sv
// rtl/axi_lite_regbank_pkg.sv - response codes, register kinds and address decode for the AXI-lite register bank
package axi_lite_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         SNAP_EN_BIT = 0;

  typedef enum logic [2:0] {
    REG_STATUS,
    REG_CTRL,
    REG_ID,
    REG_SNAP,
    REG_NONE
  } reg_kind_e;

  typedef enum logic [1:0] {
    RD_INIT,
    RD_IDLE,
    RD_RESP
  } rd_state_e;

  // Word map: status words, then control words, then ID, then SNAP_CTRL.
  function automatic reg_kind_e decode_idx(input int idx, input int n_status, input int n_ctrl);
    reg_kind_e kind;
    if (idx < n_status)
      kind = REG_STATUS;
    else if (idx < n_status + n_ctrl)
      kind = REG_CTRL;
    else if (idx == n_status + n_ctrl)
      kind = REG_ID;
    else if (idx == n_status + n_ctrl + 1)
      kind = REG_SNAP;
    else
      kind = REG_NONE;
    return kind;
  endfunction

endpackage

// File: rtl/axi_lite_wr_channel.sv
// rtl/axi_lite_wr_channel.sv - AW/W holding registers, commit strobe and B channel
// The top decodes o_commit_idx and answers with i_commit_ok in the same cycle.
module axi_lite_wr_channel
  import axi_lite_regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     i_awaddr,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic                  o_commit,
  output logic [ADDR_W-3:0]     o_commit_idx,
  output logic [DATA_W-1:0]     o_commit_data,
  output logic [DATA_W/8-1:0]   o_commit_strb,
  input  logic                  i_commit_ok
);

  logic                r_alive;
  logic                r_aw_full;
  logic                r_w_full;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic [ADDR_W-3:0]   r_aw_idx;
  logic [DATA_W-1:0]   r_w_data;
  logic [DATA_W/8-1:0] r_w_strb;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_commit;
  logic w_unused;

  // r_alive keeps both READYs low while reset is held.
  assign o_awready = r_alive && !r_aw_full && !r_bvalid;
  assign o_wready  = r_alive && !r_w_full && !r_bvalid;
  assign w_aw_hs   = o_awready && i_awvalid;
  assign w_w_hs    = o_wready && i_wvalid;
  assign w_commit  = r_aw_full && r_w_full && !r_bvalid;
  assign w_unused  = ^i_awaddr[1:0];

  assign o_commit      = w_commit;
  assign o_commit_idx  = r_aw_idx;
  assign o_commit_data = r_w_data;
  assign o_commit_strb = r_w_strb;
  assign o_bvalid      = r_bvalid;
  assign o_bresp       = r_bresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alive   <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_idx  <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= i_awaddr[ADDR_W-1:2];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= i_wdata;
        r_w_strb <= i_wstrb;
      end
      // Handshakes need an empty holder and commit needs both full, so they never collide.
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= i_commit_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && i_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_lite_regbank.sv
// rtl/axi_lite_regbank.sv - AXI4-lite register bank: status words with snapshot, control words, ID and SNAP_CTRL
// Decode, register storage and the read path live here; the write handshake lives in axi_lite_wr_channel.
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int                      C_S_AXI_DATA_WIDTH = 32,
  parameter int                      C_S_AXI_ADDR_WIDTH = 8,
  parameter int                      NUM_STATUS         = 13,
  parameter int                      NUM_CTRL           = 8,
  parameter logic [NUM_CTRL*32-1:0]  CTRL_INIT          = '0,
  parameter logic [31:0]             ID_WORD            = 32'hdeadbeef
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [NUM_STATUS*32-1:0]        status_in,
  output logic [NUM_CTRL*32-1:0]          ctrl_out,
  output logic [NUM_CTRL-1:0]             ctrl_wr_pulse,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W    = C_S_AXI_DATA_WIDTH / 8;
  localparam int CTRL_BASE = NUM_STATUS;

  logic [NUM_CTRL*32-1:0]        r_ctrl;
  logic [NUM_CTRL-1:0]           r_pulse;
  logic                          r_snap_en;
  logic [NUM_STATUS*32-1:0]      r_shadow;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                    r_rresp;
  rd_state_e                     r_rd_state;

  rd_state_e                     w_rd_next;
  logic                          w_ar_hs;
  logic                          w_commit;
  logic                          w_commit_ok;
  logic [IDX_W-1:0]              w_commit_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_commit_data;
  logic [STRB_W-1:0]             w_commit_strb;
  int                            w_wr_int;
  int                            w_ar_int;
  reg_kind_e                     w_wr_kind;
  reg_kind_e                     w_rd_kind;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
  logic [1:0]                    w_rresp;
  logic                          w_unused;

  axi_lite_wr_channel #(
    .DATA_W (C_S_AXI_DATA_WIDTH),
    .ADDR_W (C_S_AXI_ADDR_WIDTH)
  ) u_wr_channel (
    .clk           (S_AXI_ACLK),
    .rst           (S_AXI_ARESET),
    .i_awaddr      (S_AXI_AWADDR),
    .i_awvalid     (S_AXI_AWVALID),
    .o_awready     (S_AXI_AWREADY),
    .i_wdata       (S_AXI_WDATA),
    .i_wstrb       (S_AXI_WSTRB),
    .i_wvalid      (S_AXI_WVALID),
    .o_wready      (S_AXI_WREADY),
    .o_bresp       (S_AXI_BRESP),
    .o_bvalid      (S_AXI_BVALID),
    .i_bready      (S_AXI_BREADY),
    .o_commit      (w_commit),
    .o_commit_idx  (w_commit_idx),
    .o_commit_data (w_commit_data),
    .o_commit_strb (w_commit_strb),
    .i_commit_ok   (w_commit_ok)
  );

  assign w_wr_int    = int'(w_commit_idx);
  assign w_ar_int    = int'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign w_wr_kind   = decode_idx(w_wr_int, NUM_STATUS, NUM_CTRL);
  assign w_rd_kind   = decode_idx(w_ar_int, NUM_STATUS, NUM_CTRL);
  assign w_commit_ok = (w_wr_kind == REG_CTRL) || (w_wr_kind == REG_SNAP);
  // Shadow word 0 is never read back: a read of index 0 returns the live value it captures.
  assign w_unused    = ^{S_AXI_ARADDR[1:0], r_shadow[31:0]};

  assign ctrl_out      = r_ctrl;
  assign ctrl_wr_pulse = r_pulse;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_ARREADY = (r_rd_state == RD_IDLE);
  assign S_AXI_RVALID  = (r_rd_state == RD_RESP);

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_ctrl    <= CTRL_INIT;
      r_pulse   <= '0;
      r_snap_en <= 1'b0;
    end else begin
      r_pulse <= '0;
      if (w_commit) begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (w_wr_int == CTRL_BASE + i) begin
            r_pulse[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (w_commit_strb[b])
                r_ctrl[i*32 + b*8 +: 8] <= w_commit_data[b*8 +: 8];
            end
          end
        end
        if (w_wr_kind == REG_SNAP && w_commit_strb[SNAP_EN_BIT/8])
          r_snap_en <= w_commit_data[SNAP_EN_BIT];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET)
      r_rd_state <= RD_INIT;
    else
      r_rd_state <= w_rd_next;
  end

  // RD_INIT holds ARREADY low for the first cycle out of reset.
  always_comb begin
    w_rd_next = r_rd_state;
    w_ar_hs   = 1'b0;
    case (r_rd_state)
      RD_INIT: w_rd_next = RD_IDLE;
      RD_IDLE: begin
        if (S_AXI_ARVALID) begin
          w_ar_hs   = 1'b1;
          w_rd_next = RD_RESP;
        end
      end
      RD_RESP: begin
        if (S_AXI_RREADY)
          w_rd_next = RD_IDLE;
      end
      default: w_rd_next = RD_INIT;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    w_rresp = RESP_OKAY;
    case (w_rd_kind)
      REG_STATUS: begin
        for (int i = 0; i < NUM_STATUS; i++) begin
          if (w_ar_int == i)
            w_rdata = (r_snap_en && i != 0) ? r_shadow[i*32 +: 32] : status_in[i*32 +: 32];
        end
      end
      REG_CTRL: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (w_ar_int == CTRL_BASE + i)
            w_rdata = r_ctrl[i*32 +: 32];
        end
      end
      REG_ID:   w_rdata = ID_WORD;
      REG_SNAP: w_rdata[SNAP_EN_BIT] = r_snap_en;
      default:  w_rresp = RESP_SLVERR;
    endcase
  end

  // r_ctrl is sampled before this edge's commit, so a colliding read sees the old value.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_shadow <= '0;
    end else if (w_ar_hs) begin
      r_rdata <= w_rdata;
      r_rresp <= w_rresp;
      if (w_rd_kind == REG_STATUS && w_ar_int == 0)
        r_shadow <= status_in;
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb/tb_axi_lite_regbank.sv - self-checking bench for axi_lite_regbank with B/R response scoreboards
module tb_axi_lite_regbank;

  localparam int NS = 13;
  localparam int NC = 8;
  localparam logic [NC*32-1:0] INIT = {32'hA5A50007, 32'h0, 32'h0, 32'h0,
                                       32'h0, 32'h0, 32'h11112222, 32'h0};
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NS*32-1:0]  status_in = '0;
  logic [NC*32-1:0]  ctrl_out;
  logic [NC-1:0]     ctrl_wr_pulse;
  logic [7:0]        awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [7:0]        araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;

  always #5 clk = ~clk;

  axi_lite_regbank #(
    .NUM_STATUS (NS),
    .NUM_CTRL   (NC),
    .CTRL_INIT  (INIT)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .status_in     (status_in),
    .ctrl_out      (ctrl_out),
    .ctrl_wr_pulse (ctrl_wr_pulse),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  int errors = 0;
  int checks = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [31:0] model_ctrl[NC];

  task automatic model_reset();
    logic [NC*32-1:0] v;
    v = INIT;
    for (int i = 0; i < NC; i++) model_ctrl[i] = v[i*32 +: 32];
  endtask

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    if (idx >= NS && idx < NS + NC)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_ctrl[idx-NS][b*8 +: 8] = data[b*8 +: 8];
  endtask

  function automatic logic [NC*32-1:0] model_flat();
    logic [NC*32-1:0] v;
    for (int i = 0; i < NC; i++) v[i*32 +: 32] = model_ctrl[i];
    return v;
  endfunction

  task automatic do_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [NC-1:0] pulse_b,
                          output logic [NC-1:0] pulse_nxt, output bit tmo);
    int n;
    bit aw_hs, w_hs;
    @(negedge clk);
    awaddr = 8'(idx << 2); awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    tmo = !bvalid;
    resp = bresp;
    pulse_b = ctrl_wr_pulse;
    @(negedge clk);
    pulse_nxt = ctrl_wr_pulse;
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic do_read(input int idx, output logic [31:0] data, output logic [1:0] resp,
                         output bit tmo);
    int n;
    bit hs;
    @(negedge clk);
    araddr = 8'(idx << 2); arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 50) begin
      hs = arready;
      @(negedge clk);
      if (hs) arvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    tmo = !rvalid;
    data = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0; arvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin errors++; $display("FAIL reset_handshake got=%b expected=00000", {awready, wready, arready, bvalid, rvalid}); end
    checks++; if ({bresp, rresp, rdata} !== 36'h0) begin errors++; $display("FAIL reset_resp got=%h expected=0", {bresp, rresp, rdata}); end
    checks++; if (ctrl_out !== INIT) begin errors++; $display("FAIL reset_ctrl got=%h expected=%h", ctrl_out, INIT); end
    checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL reset_pulse got=%b expected=0", ctrl_wr_pulse); end
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL reset_release_ready got=%b expected=111", {awready, wready, arready}); end
  endtask

  task automatic test_strobe_write();
    logic [1:0] resp; logic [NC-1:0] pb, pn; bit tmo;
    exp_b_q.push_back(OKAY); model_write(13, 32'h12345678, 4'b0101);
    do_write(13, 32'h12345678, 4'b0101, resp, pb, pn, tmo);
    checks++; if (tmo || resp !== exp_b_q.pop_front()) begin errors++; $display("FAIL strb_bresp got=%b tmo=%0d expected=OKAY", resp, tmo); end
    checks++; if (ctrl_out[31:0] !== 32'h00340078) begin errors++; $display("FAIL strb_ctrl0 got=%h expected=00340078", ctrl_out[31:0]); end
    checks++; if (pb !== 8'h01 || pn !== 8'h00) begin errors++; $display("FAIL strb_pulse got=%h,%h expected=01,00", pb, pn); end
    exp_b_q.push_back(OKAY); model_write(14, 32'hFFFFFFFF, 4'b0000);
    do_write(14, 32'hFFFFFFFF, 4'b0000, resp, pb, pn, tmo);
    checks++; if (tmo || resp !== exp_b_q.pop_front()) begin errors++; $display("FAIL strb0_bresp got=%b tmo=%0d expected=OKAY", resp, tmo); end
    checks++; if (pb !== 8'h02 || pn !== 8'h00) begin errors++; $display("FAIL strb0_pulse got=%h,%h expected=02,00", pb, pn); end
    checks++; if (ctrl_out !== model_flat()) begin errors++; $display("FAIL strb0_ctrl got=%h expected=%h", ctrl_out, model_flat()); end
  endtask

  task automatic test_w_before_aw();
    int nb;
    exp_b_q.push_back(OKAY); model_write(15, 32'hCAFEBABE, 4'hF);
    @(negedge clk);
    wdata = 32'hCAFEBABE; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL wfirst_wready got=%b expected=1", wready); end
    @(negedge clk);
    wvalid = 1'b0;
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wfirst_held got=%b expected=0", wready); end
    repeat (2) @(negedge clk);
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_early_b got=%b expected=0", bvalid); end
    awaddr = 8'(15 << 2); awvalid = 1'b1;
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL wfirst_awready got=%b expected=1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
    checks++; if (bvalid !== 1'b0 || ctrl_wr_pulse !== '0) begin errors++; $display("FAIL wfirst_commit_early got=%b,%h expected=0,00", bvalid, ctrl_wr_pulse); end
    @(negedge clk);
    checks++; if (bvalid !== 1'b1 || bresp !== exp_b_q.pop_front() || ctrl_wr_pulse !== 8'h04) begin errors++; $display("FAIL wfirst_commit got=%b,%b,%h expected=1,OKAY,04", bvalid, bresp, ctrl_wr_pulse); end
    checks++; if (ctrl_out !== model_flat()) begin errors++; $display("FAIL wfirst_ctrl got=%h expected=%h", ctrl_out, model_flat()); end
    nb = 1;
    repeat (6) begin
      @(negedge clk);
      if (bvalid) nb++;
    end
    bready = 1'b0;
    checks++; if (nb !== 1) begin errors++; $display("FAIL wfirst_b_count got=%0d expected=1", nb); end
  endtask

  task automatic test_slverr();
    logic [1:0] resp; logic [NC-1:0] pb, pn; bit tmo; logic [31:0] d; logic [33:0] e;
    exp_b_q.push_back(SLVERR);
    do_write(2, 32'hFFFFFFFF, 4'hF, resp, pb, pn, tmo);
    checks++; if (tmo || resp !== exp_b_q.pop_front()) begin errors++; $display("FAIL status_wr_bresp got=%b tmo=%0d expected=SLVERR", resp, tmo); end
    checks++; if (ctrl_out !== model_flat() || pb !== '0) begin errors++; $display("FAIL status_wr_state got=%h pulse=%h expected=%h pulse=00", ctrl_out, pb, model_flat()); end
    exp_b_q.push_back(SLVERR);
    do_write(21, 32'h0, 4'hF, resp, pb, pn, tmo);
    checks++; if (tmo || resp !== exp_b_q.pop_front()) begin errors++; $display("FAIL id_wr_bresp got=%b tmo=%0d expected=SLVERR", resp, tmo); end
    exp_r_q.push_back({SLVERR, 32'h0});
    do_read(60, d, resp, tmo); e = exp_r_q.pop_front();
    checks++; if (tmo || {resp, d} !== e) begin errors++; $display("FAIL unmapped_rd got=%h tmo=%0d expected=%h", {resp, d}, tmo, e); end
    exp_r_q.push_back({OKAY, 32'hdeadbeef});
    do_read(21, d, resp, tmo); e = exp_r_q.pop_front();
    checks++; if (tmo || {resp, d} !== e) begin errors++; $display("FAIL id_rd got=%h tmo=%0d expected=%h", {resp, d}, tmo, e); end
    exp_r_q.push_back({OKAY, model_ctrl[0]});
    do_read(13, d, resp, tmo); e = exp_r_q.pop_front();
    checks++; if (tmo || {resp, d} !== e) begin errors++; $display("FAIL ctrl0_rd got=%h tmo=%0d expected=%h", {resp, d}, tmo, e); end
    status_in[2*32 +: 32] = 32'h5A5A1234;
    exp_r_q.push_back({OKAY, 32'h5A5A1234});
    do_read(2, d, resp, tmo); e = exp_r_q.pop_front();
    checks++; if (tmo || {resp, d} !== e) begin errors++; $display("FAIL status_live_rd got=%h tmo=%0d expected=%h", {resp, d}, tmo, e); end
  endtask

  task automatic test_snapshot();
    logic [1:0] resp; logic [NC-1:0] pb, pn; bit tmo; logic [31:0] d; logic [33:0] e;
    exp_b_q.push_back(OKAY);
    do_write(22, 32'hFFFFFFFF, 4'hF, resp, pb, pn, tmo);
    checks++; if (tmo || resp !== exp_b_q.pop_front()) begin errors++; $display("FAIL snap_wr_bresp got=%b tmo=%0d expected=OKAY", resp, tmo); end
    exp_r_q.push_back({OKAY, 32'h1});
    do_read(22, d, resp, tmo); e = exp_r_q.pop_front();
    checks++; if (tmo || {resp, d} !== e) begin errors++; $display("FAIL snap_rd got=%h tmo=%0d expected=%h", {resp, d}, tmo, e); end
    status_in[0 +: 32] = 32'h00000777;
    status_in[32 +: 32] = 32'h0000000A;
    exp_r_q.push_back({OKAY, 32'h00000777});
    do_read(0, d, resp, tmo); e = exp_r_q.pop_front();
    checks++; if (tmo || {resp, d} !== e) begin errors++; $display("FAIL snap_trigger_rd got=%h tmo=%0d expected=%h", {resp, d}, tmo, e); end
    status_in[32 +: 32] = 32'h0000000B;
    exp_r_q.push_back({OKAY, 32'h0000000A});
    do_read(1, d, resp, tmo); e = exp_r_q.pop_front();
    checks++; if (tmo || {resp, d} !== e) begin errors++; $display("FAIL snap_shadow_rd got=%h tmo=%0d expected=%h", {resp, d}, tmo, e); end
    exp_b_q.push_back(OKAY);
    do_write(22, 32'h0, 4'hF, resp, pb, pn, tmo);
    checks++; if (tmo || resp !== exp_b_q.pop_front()) begin errors++; $display("FAIL snap_off_bresp got=%b tmo=%0d expected=OKAY", resp, tmo); end
    exp_r_q.push_back({OKAY, 32'h0000000B});
    do_read(1, d, resp, tmo); e = exp_r_q.pop_front();
    checks++; if (tmo || {resp, d} !== e) begin errors++; $display("FAIL snap_live_rd got=%h tmo=%0d expected=%h", {resp, d}, tmo, e); end
  endtask

  task automatic test_rready_stall();
    logic [31:0] d0; logic [33:0] e; bit stable;
    exp_r_q.push_back({OKAY, model_ctrl[2]});
    @(negedge clk);
    araddr = 8'(15 << 2); arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    d0 = rdata; e = exp_r_q.pop_front();
    checks++; if (rvalid !== 1'b1 || {rresp, d0} !== e) begin errors++; $display("FAIL stall_first got=%b,%h expected=1,%h", rvalid, {rresp, d0}, e); end
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL stall_hold got=%b,%h,%b expected=1,%h,0", rvalid, rdata, arready, d0); end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b,%b expected=0,1", rvalid, arready); end
  endtask

  task automatic test_back_to_back();
    logic [33:0] e; logic [1:0] eb;
    exp_r_q.push_back({OKAY, model_ctrl[3]});
    exp_b_q.push_back(OKAY);
    model_write(16, 32'h5555AAAA, 4'hF);
    @(negedge clk);
    awaddr = 8'(16 << 2); awvalid = 1'b1; wdata = 32'h5555AAAA; wstrb = 4'hF; wvalid = 1'b1;
    rready = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'(16 << 2); arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    e = exp_r_q.pop_front(); eb = exp_b_q.pop_front();
    checks++; if ({rvalid, bvalid} !== 2'b11) begin errors++; $display("FAIL b2b_concurrent got=%b expected=11", {rvalid, bvalid}); end
    checks++; if ({rresp, rdata} !== e) begin errors++; $display("FAIL b2b_precommit_rd got=%h expected=%h", {rresp, rdata}, e); end
    checks++; if (bresp !== eb || ctrl_out !== model_flat()) begin errors++; $display("FAIL b2b_commit got=%b,%h expected=%b,%h", bresp, ctrl_out, eb, model_flat()); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    checks++; if ({rvalid, bvalid} !== 2'b00) begin errors++; $display("FAIL b2b_drain got=%b expected=00", {rvalid, bvalid}); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [NC-1:0] pb, pn; bit tmo; int nb;
    @(negedge clk);
    awaddr = 8'(13 << 2); awvalid = 1'b1;
    wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0;
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rstmid_aw_held got=%b expected=0", awready); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    nb = 0;
    repeat (5) begin
      @(negedge clk);
      if (bvalid) nb++;
    end
    checks++; if (nb !== 0) begin errors++; $display("FAIL rstmid_no_b got=%0d expected=0", nb); end
    checks++; if (ctrl_out !== INIT) begin errors++; $display("FAIL rstmid_ctrl got=%h expected=%h", ctrl_out, INIT); end
    exp_b_q.push_back(OKAY); model_write(13, 32'h0BADF00D, 4'hF);
    do_write(13, 32'h0BADF00D, 4'hF, resp, pb, pn, tmo);
    checks++; if (tmo || resp !== exp_b_q.pop_front() || pb !== 8'h01) begin errors++; $display("FAIL rstmid_next_wr got=%b,%h tmo=%0d expected=OKAY,01", resp, pb, tmo); end
    checks++; if (ctrl_out !== model_flat()) begin errors++; $display("FAIL rstmid_next_ctrl got=%h expected=%h", ctrl_out, model_flat()); end
  endtask

  initial begin
    test_reset();
    test_strobe_write();
    test_w_before_aw();
    test_slverr();
    test_snapshot();
    test_rready_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
